// File: rtl/mod_instr_fetch_pkg.sv
// Shared definitions for the instruction-fetch front end: FSM encodings, MIPS field positions,
// opcode constants and PC helper functions.
package mod_instr_fetch_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned RS_MSB     = 25;
  localparam int unsigned RS_LSB     = 21;
  localparam int unsigned RT_MSB     = 20;
  localparam int unsigned RT_LSB     = 16;
  localparam int unsigned RD_MSB     = 15;
  localparam int unsigned RD_LSB     = 11;
  localparam int unsigned SHAMT_MSB  = 10;
  localparam int unsigned SHAMT_LSB  = 6;
  localparam int unsigned FUNCT_MSB  = 5;
  localparam int unsigned FUNCT_LSB  = 0;
  localparam int unsigned IMM_MSB    = 15;
  localparam int unsigned TARGET_MSB = 25;

  localparam logic [5:0] J_OPCODE   = 6'h02;
  localparam logic [5:0] BEQ_OPCODE = 6'h04;

  // Word-aligned, sign-extended branch displacement.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

  // Jump target stays inside the 256 MB region of the delay-slot address.
  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [25:0] target);
    return {pc_plus4[31:28], target, 2'b00};
  endfunction

endpackage

// File: rtl/mod_next_pc.sv
// Combinational next-PC resolution: jump beats taken branch beats sequential.
module mod_next_pc
  import mod_instr_fetch_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [25:0] instr_low,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  output logic [31:0] next_pc
);

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_target(pc_plus4, instr_low[TARGET_MSB:0]);
    end else if (branch && zero) begin
      next_pc = pc_plus4 + branch_offset(instr_low[IMM_MSB:0]);
    end
  end

endmodule

// File: rtl/mod_instr_fetch.sv
// Instruction-fetch front end: PC, imem req/ack fetch, field split and valid/ready issue.
// Optional IFETCH_PERF_CNT_EN adds fetch_cnt / redirect_cnt performance counters.
module mod_instr_fetch
  import mod_instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
`ifdef IFETCH_PERF_CNT_EN
  output logic [31:0] fetch_cnt,
  output logic [31:0] redirect_cnt,
`endif
  input  logic        jump,
  input  logic        branch,
  input  logic        zero
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] next_pc;
  logic        accept;

  assign accept = (state_q == S_ISSUE) && instr_ready;

  mod_next_pc u_next_pc (
    .pc_plus4  (pc_plus4),
    .instr_low (instr_q[TARGET_MSB:0]),
    .jump      (jump),
    .branch    (branch),
    .zero      (zero),
    .next_pc   (next_pc)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (instr_ready) begin
          pc_d    = next_pc;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Decode fields come only from the registered word, never straight from imem_rdata.
  always_comb begin
    imem_req    = (state_q == S_FETCH);
    instr_valid = (state_q == S_ISSUE);
    imem_addr   = pc_q;
    pc          = pc_q;
    pc_plus4    = pc_q + 32'd4;
    opcode      = instr_q[OPCODE_MSB:OPCODE_LSB];
    rs          = instr_q[RS_MSB:RS_LSB];
    rt          = instr_q[RT_MSB:RT_LSB];
    rd          = instr_q[RD_MSB:RD_LSB];
    shamt       = instr_q[SHAMT_MSB:SHAMT_LSB];
    funct       = instr_q[FUNCT_MSB:FUNCT_LSB];
    imm         = instr_q[IMM_MSB:0];
  end

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] redirect_cnt_q, redirect_cnt_d;

  always_comb begin
    fetch_cnt_d    = fetch_cnt_q;
    redirect_cnt_d = redirect_cnt_q;
    if (accept) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
      if (next_pc != pc_plus4) begin
        redirect_cnt_d = redirect_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      fetch_cnt_q    <= fetch_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign fetch_cnt    = fetch_cnt_q;
  assign redirect_cnt = redirect_cnt_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_mod_instr_fetch.sv
// Scoreboard bench for mod_instr_fetch: directed opening sequence, then randomized memory
// latency, ready stalls and control inputs against a PC reference model.
module tb_mod_instr_fetch;
  import mod_instr_fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int NDIR = 10;
  localparam int NRAND = 300;

  logic        clk, rst_n;
  logic        imem_req, imem_ack, instr_valid, instr_ready;
  logic [31:0] imem_addr, imem_rdata, pc, pc_plus4;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic        jump, branch, zero;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, redirect_cnt;
  logic [31:0] exp_fetch, exp_redir;
`endif

  mod_instr_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .opcode       (opcode),
    .rs           (rs),
    .rt           (rt),
    .rd           (rd),
    .shamt        (shamt),
    .funct        (funct),
    .imm          (imm),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
`ifdef IFETCH_PERF_CNT_EN
    .fetch_cnt    (fetch_cnt),
    .redirect_cnt (redirect_cnt),
`endif
    .jump         (jump),
    .branch       (branch),
    .zero         (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    int          delay;
    logic [31:0] instr;
    int          rdelay;
    bit          j;
    bit          b;
    bit          z;
  } fetch_t;

  exp_t        instr_q[$];
  logic [31:0] addr_q[$];
  int          n_checks = 0;
  int          n_err = 0;

  logic [31:0] model_pc;
  int          accepts, cycles, dir_idx, wait_cnt, rwait_cnt;
  fetch_t      dir[NDIR];
  fetch_t      cur_fetch, cur_issue;
  bit          fetch_active, issue_active, ack_prev, accept_prev;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference next PC from the architectural rules, in plain arithmetic.
  function automatic logic [31:0] ref_next_pc(input logic [31:0] cur, input logic [31:0] instr,
                                              input bit j, input bit b, input bit z);
    logic [31:0] seq;
    int          off;
    seq = cur + 32'd4;
    if (j) return (seq & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) << 2);
    if (b && z) begin
      off = $signed(instr[15:0]);
      return seq + 32'(off * 4);
    end
    return seq;
  endfunction

  function automatic fetch_t pick_random();
    fetch_t      f;
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 3))
      0: w[31:26] = J_OPCODE;
      1: w[31:26] = BEQ_OPCODE;
      2: w[31:26] = 6'h00;
      default: ;
    endcase
    f.delay  = int'($urandom_range(0, 3));
    f.instr  = w;
    f.rdelay = int'($urandom_range(0, 3));
    f.j      = ($urandom_range(0, 3) == 0);
    f.b      = 1'($urandom_range(0, 1));
    f.z      = 1'($urandom_range(0, 1));
    return f;
  endfunction

  // One cycle of memory / decode-side stimulus, called #1 after each rising edge.
  task automatic step();
    logic [31:0] nxt;
    exp_t        e;
    if (ack_prev) chk("valid_latency", 32'(instr_valid), 32'd1);
    if (accept_prev) chk("refetch_latency", 32'(imem_req), 32'd1);
    ack_prev    = 1'b0;
    accept_prev = 1'b0;

    if (imem_req) begin
      if (!fetch_active) begin
        fetch_active = 1'b1;
        if (dir_idx < NDIR) begin
          cur_fetch = dir[dir_idx];
          dir_idx++;
        end else begin
          cur_fetch = pick_random();
        end
        wait_cnt = cur_fetch.delay;
      end
      if (wait_cnt == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = cur_fetch.instr;
        e.pc       = model_pc;
        e.instr    = cur_fetch.instr;
        instr_q.push_back(e);
        cur_issue    = cur_fetch;
        fetch_active = 1'b0;
        ack_prev     = 1'b1;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        wait_cnt--;
      end
    end else begin
      imem_ack   = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
    end

    if (instr_valid) begin
      if (!issue_active) begin
        issue_active = 1'b1;
        rwait_cnt    = cur_issue.rdelay;
      end
      if (rwait_cnt == 0) begin
        instr_ready = 1'b1;
        jump        = cur_issue.j;
        branch      = cur_issue.b;
        zero        = cur_issue.z;
        nxt = ref_next_pc(model_pc, cur_issue.instr, cur_issue.j, cur_issue.b, cur_issue.z);
`ifdef IFETCH_PERF_CNT_EN
        exp_fetch++;
        if (nxt != model_pc + 32'd4) exp_redir++;
`endif
        model_pc = nxt;
        addr_q.push_back(nxt);
        accepts++;
        issue_active = 1'b0;
        accept_prev  = 1'b1;
      end else begin
        instr_ready = 1'b0;
        jump        = 1'($urandom_range(0, 1));
        branch      = 1'($urandom_range(0, 1));
        zero        = 1'($urandom_range(0, 1));
        rwait_cnt--;
      end
    end else begin
      instr_ready = 1'($urandom_range(0, 1));
      jump        = 1'($urandom_range(0, 1));
      branch      = 1'($urandom_range(0, 1));
      zero        = 1'($urandom_range(0, 1));
    end
  endtask

  // Monitor: pops expectations when req/valid rise, re-checks them while held.
  logic        rst_at_edge;
  logic        prev_req, prev_valid;
  logic [31:0] cur_addr;
  exp_t        cur_exp;

  always @(posedge clk) rst_at_edge <= !rst_n;

  always @(negedge clk) begin
    if (rst_at_edge) begin
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_addr", imem_addr, RESET_PC);
      chk("rst_pc", pc, RESET_PC);
      chk("rst_pc4", pc_plus4, RESET_PC + 32'd4);
      chk("rst_fields", {opcode, rs, rt, rd, shamt, funct}, 32'd0);
      chk("rst_imm", 32'(imm), 32'd0);
`ifdef IFETCH_PERF_CNT_EN
      chk("rst_fetch_cnt", fetch_cnt, 32'd0);
      chk("rst_redirect_cnt", redirect_cnt, 32'd0);
`endif
      prev_req   = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (imem_req && instr_valid) chk("req_valid_exclusive", 32'd1, 32'd0);
      if (imem_req) begin
        if (!prev_req) begin
          if (addr_q.size() == 0) begin
            chk("unexpected_fetch", imem_addr, 32'hFFFF_FFFF);
            cur_addr = imem_addr ^ 32'h1;
          end else begin
            cur_addr = addr_q.pop_front();
          end
`ifdef IFETCH_PERF_CNT_EN
          chk("fetch_cnt", fetch_cnt, exp_fetch);
          chk("redirect_cnt", redirect_cnt, exp_redir);
`endif
        end
        chk("imem_addr", imem_addr, cur_addr);
      end
      if (instr_valid) begin
        if (!prev_valid) begin
          if (instr_q.size() == 0) begin
            chk("unexpected_valid", 32'(instr_valid), 32'd0);
            cur_exp.pc    = ~pc;
            cur_exp.instr = 32'h0;
          end else begin
            cur_exp = instr_q.pop_front();
          end
        end
        chk("pc", pc, cur_exp.pc);
        chk("pc_plus4", pc_plus4, cur_exp.pc + 32'd4);
        chk("opcode", 32'(opcode), 32'(cur_exp.instr[31:26]));
        chk("rs_rt_rd", {17'd0, rs, rt, rd}, {17'd0, cur_exp.instr[25:11]});
        chk("shamt", 32'(shamt), 32'(cur_exp.instr[10:6]));
        chk("funct", 32'(funct), 32'(cur_exp.instr[5:0]));
        chk("imm", 32'(imm), 32'(cur_exp.instr[15:0]));
      end
      prev_req   = imem_req;
      prev_valid = instr_valid;
    end
  end

  initial begin
    dir[0] = '{0, 32'h0000_0020, 0, 1'b0, 1'b0, 1'b0};  // add at 0
    dir[1] = '{3, 32'h0109_5020, 0, 1'b0, 1'b0, 1'b0};  // 3 wait states at 4
    dir[2] = '{0, 32'h0000_0022, 5, 1'b0, 1'b0, 1'b0};  // ready stall at 8
    dir[3] = '{0, 32'h0800_0004, 0, 1'b1, 1'b0, 1'b0};  // j 0x10
    dir[4] = '{0, 32'h1000_FFFC, 0, 1'b0, 1'b1, 1'b1};  // beq taken -> 0x04
    dir[5] = '{1, 32'h0800_0004, 1, 1'b1, 1'b0, 1'b1};  // j 0x10
    dir[6] = '{0, 32'h1000_FFFC, 0, 1'b0, 1'b1, 1'b0};  // beq not taken -> 0x14
    dir[7] = '{0, 32'h0BFF_FFFF, 0, 1'b1, 1'b0, 1'b0};  // j 0x0FFF_FFFC
    dir[8] = '{2, 32'h0000_0020, 0, 1'b0, 1'b1, 1'b0};  // -> 0x1000_0000
    dir[9] = '{0, 32'h0800_0040, 0, 1'b1, 1'b1, 1'b1};  // jump wins -> 0x1000_0100

    rst_n        = 1'b0;
    imem_ack     = 1'b0;
    imem_rdata   = 32'h0;
    instr_ready  = 1'b0;
    jump         = 1'b0;
    branch       = 1'b0;
    zero         = 1'b0;
    prev_req     = 1'b0;
    prev_valid   = 1'b0;
    model_pc     = RESET_PC;
    accepts      = 0;
    dir_idx      = 0;
    fetch_active = 1'b0;
    issue_active = 1'b0;
    ack_prev     = 1'b0;
    accept_prev  = 1'b0;
`ifdef IFETCH_PERF_CNT_EN
    exp_fetch = '0;
    exp_redir = '0;
`endif
    addr_q.push_back(RESET_PC);

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("idle_no_req", 32'(imem_req), 32'd0);
    @(posedge clk);
    #1;
    chk("req_latency", 32'(imem_req), 32'd1);
    step();

    cycles = 0;
    while (accepts < NDIR + NRAND && cycles < 20000) begin
      @(posedge clk);
      #1;
      step();
      cycles++;
    end
    chk("main_progress", 32'(accepts), 32'(NDIR + NRAND));

    // Reset in the middle of a fetch wait, with an ack on the same edge.
    cycles = 0;
    while (cycles < 100) begin
      @(posedge clk);
      #1;
      if (imem_req && !fetch_active) break;
      step();
      cycles++;
    end
    imem_ack    = 1'b0;
    instr_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_reset_req", 32'(imem_req), 32'd1);
    rst_n      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    instr_q.delete();
    addr_q.delete();
    addr_q.push_back(RESET_PC);
    model_pc     = RESET_PC;
    fetch_active = 1'b0;
    issue_active = 1'b0;
    ack_prev     = 1'b0;
    accept_prev  = 1'b0;
`ifdef IFETCH_PERF_CNT_EN
    exp_fetch = '0;
    exp_redir = '0;
`endif
    @(posedge clk);
    #1;
    chk("mid_rst_req", 32'(imem_req), 32'd0);
    chk("mid_rst_valid", 32'(instr_valid), 32'd0);
    rst_n    = 1'b1;
    imem_ack = 1'b0;
    @(posedge clk);
    #1;
    chk("refetch_after_reset", 32'(imem_req), 32'd1);
    step();

    accepts = 0;
    cycles  = 0;
    while (accepts < 20 && cycles < 2000) begin
      @(posedge clk);
      #1;
      step();
      cycles++;
    end
    chk("post_reset_progress", 32'(accepts), 32'd20);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
